// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared types, constants and helpers for the DHT11/DHT22 reader
package dht_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK,
        ST_COOLDOWN
    } dht_state_e;

    localparam int US_PER_MS = 1000;
    localparam int NUM_BITS  = 40;

    function automatic int us_cycles(input int freq);
        return freq / 1_000_000;
    endfunction

endpackage

// File: rtl/dht_us_tick.sv
// rtl/dht_us_tick.sv - microsecond prescaler, restartable so each phase starts on a fresh microsecond
module dht_us_tick #(
    parameter int CYCLES = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dht_reader.sv
// rtl/dht_reader.sv - single-wire DHT11/DHT22 40-bit reader with checksum, timeouts, cooldown and auto-trigger
module dht_reader
    import dht_pkg::*;
#(
    parameter int CLK_FREQ        = 12_000_000,
    parameter int START_MS        = 18,
    parameter int TIMEOUT_US      = 200,
    parameter int BIT_THRESH_US   = 50,
    parameter int MIN_INTERVAL_MS = 1000,
    parameter int AUTO_PERIOD_MS  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic        busy,
    output logic        valid,
    output logic [39:0] data,
    output logic        crc_ok,
    output logic        err_timeout
);

    localparam logic [19:0] START_US  = 20'(START_MS * US_PER_MS);
    localparam logic [19:0] TOUT_US   = 20'(TIMEOUT_US);
    localparam logic [19:0] THRESH_US = 20'(BIT_THRESH_US);
    localparam logic [19:0] COOL_US   = 20'(MIN_INTERVAL_MS * US_PER_MS);
    localparam logic [19:0] AUTO_US   = 20'(AUTO_PERIOD_MS * US_PER_MS);
    localparam logic [5:0]  LAST_BIT  = 6'(NUM_BITS - 1);

    dht_state_e  state_q, state_d;
    logic [2:0]  sync_q;
    logic        rise, fall;
    logic        us_tick, state_chg;
    logic [19:0] us_cnt_q;
    logic        timed_out, auto_fire, wait_state, tout_d;
    logic [39:0] shift_q, shift_d, frame_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  sum_d;
    logic        crc_d;
    logic [39:0] data_q;
    logic        crc_q, err_q;

    // Two flops of synchroniser, the third holds the previous sample for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], dht_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    assign state_chg = (state_d != state_q);

    dht_us_tick #(
        .CYCLES(us_cycles(CLK_FREQ))
    ) u_us_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (state_chg),
        .tick (us_tick)
    );

    // Phase timer doubles as the auto-trigger timer while in IDLE.
    always_ff @(posedge clk) begin
        if (reset || state_chg) begin
            us_cnt_q <= '0;
        end else if (us_tick && (us_cnt_q != '1)) begin
            us_cnt_q <= us_cnt_q + 1'b1;
        end
    end

    assign timed_out = (us_cnt_q >= TOUT_US);
    assign auto_fire = (AUTO_PERIOD_MS != 0) && (us_cnt_q >= AUTO_US);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_state = 1'b0;
        tout_d     = 1'b0;
        case (state_q)
            ST_IDLE:      if (start || auto_fire) state_d = ST_START_LOW;
            ST_START_LOW: if (us_cnt_q >= START_US) state_d = ST_RELEASE;
            ST_RELEASE: begin
                wait_state = 1'b1;
                if (fall) state_d = ST_RESP_LOW;
            end
            ST_RESP_LOW: begin
                wait_state = 1'b1;
                if (rise) state_d = ST_RESP_HIGH;
            end
            ST_RESP_HIGH: begin
                wait_state = 1'b1;
                if (fall) state_d = ST_BIT_LOW;
            end
            ST_BIT_LOW: begin
                wait_state = 1'b1;
                if (rise) state_d = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                wait_state = 1'b1;
                if (fall) state_d = (bit_cnt_q == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
            end
            ST_CHECK:     state_d = ST_COOLDOWN;
            ST_COOLDOWN:  if (us_cnt_q >= COOL_US) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // An edge in the same cycle wins over the timeout.
        if (wait_state && (state_d == state_q) && timed_out) begin
            state_d = ST_CHECK;
            tout_d  = 1'b1;
        end
    end

    always_comb begin
        dht_oe = (state_q == ST_START_LOW);
        busy   = (state_q != ST_IDLE);
        valid  = (state_q == ST_CHECK);
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (state_q == ST_START_LOW) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if ((state_q == ST_BIT_HIGH) && fall) begin
            shift_d   = {shift_q[38:0], (us_cnt_q > THRESH_US)};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        // Left-justify so a partial frame keeps its bits at the MSB end.
        frame_d = shift_d << (6'(NUM_BITS) - bit_cnt_d);
        sum_d   = shift_d[39:32] + shift_d[31:24] + shift_d[23:16] + shift_d[15:8];
        crc_d   = !tout_d && (sum_d == shift_d[7:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            crc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            if (state_d == ST_CHECK) begin
                data_q <= frame_d;
                crc_q  <= crc_d;
                err_q  <= tout_d;
            end
        end
    end

    assign data        = data_q;
    assign crc_ok      = crc_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_dht_reader.sv
// tb/tb_dht_reader.sv - scoreboard bench for dht_reader with a DHT sensor model and an auto-trigger instance
`timescale 1ns/1ps
module tb_dht_reader;

    localparam int CPU    = 2;
    localparam int LIMIT  = 30000;
    localparam logic [39:0] F1 = 40'h37_00_19_00_50;
    localparam logic [39:0] F2 = 40'h37_00_19_00_51;
    localparam logic [39:0] F3 = 40'h4B_80_0A_33_08;
    localparam logic [39:0] F4 = 40'hA5_FF_00_00_A4;

    typedef struct packed {
        logic [39:0] data;
        logic        crc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, drv_low = 1'b0;
    logic        reset_a = 1'b1, start_a = 1'b0;
    logic        line, line_a;
    logic        dht_oe, busy, valid, crc_ok, err_timeout;
    logic        oe_a, busy_a, valid_a, crc_a, err_a;
    logic [39:0] data, data_a;

    int   n_vec = 0, n_err = 0, n_valid = 0, n_valid_a = 0, bit_idx = -1;
    exp_t sb_q[$];
    exp_t mon_e;

    assign line   = !(dht_oe || drv_low);
    assign line_a = !oe_a;

    always #250 clk = ~clk;

    dht_reader #(
        .CLK_FREQ(2_000_000), .START_MS(1), .TIMEOUT_US(200),
        .BIT_THRESH_US(50), .MIN_INTERVAL_MS(2), .AUTO_PERIOD_MS(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .dht_in(line),
        .dht_oe(dht_oe), .busy(busy), .valid(valid), .data(data),
        .crc_ok(crc_ok), .err_timeout(err_timeout)
    );

    dht_reader #(
        .CLK_FREQ(2_000_000), .START_MS(1), .TIMEOUT_US(200),
        .BIT_THRESH_US(50), .MIN_INTERVAL_MS(2), .AUTO_PERIOD_MS(3)
    ) dut_auto (
        .clk(clk), .reset(reset_a), .start(start_a), .dht_in(line_a),
        .dht_oe(oe_a), .busy(busy_a), .valid(valid_a), .data(data_a),
        .crc_ok(crc_a), .err_timeout(err_a)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic crc_of(input logic [39:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s == f[7:0];
    endfunction

    task automatic wait_us(input int n);
        repeat (n * CPU) @(negedge clk);
    endtask

    // Host pulls low, then the sensor answers with 80/80 us response and nbits of 20 us low + 24/76 us high.
    task automatic sensor(input logic [39:0] frame, input int nbits);
        int t;
        bit_idx = -1;
        t = 0;
        while (!dht_oe && t < LIMIT) begin @(negedge clk); t++; end
        while (dht_oe && t < LIMIT) begin @(negedge clk); t++; end
        check_eq("model_sync", t < LIMIT, 1);
        wait_us(20);
        drv_low = 1'b1; wait_us(80);
        drv_low = 1'b0; wait_us(80);
        for (int i = 0; i < nbits; i++) begin
            bit_idx = i;
            drv_low = 1'b1; wait_us(20);
            drv_low = 1'b0; wait_us(frame[39-i] ? 76 : 24);
        end
        if (nbits == 40) begin
            drv_low = 1'b1; wait_us(50);
            drv_low = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_eq("start_oe", dht_oe, 1);
        check_eq("start_busy", busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < LIMIT) begin @(negedge clk); t++; end
        check_eq({tag, "_idle"}, t < LIMIT, 1);
    endtask

    task automatic do_read(input logic [39:0] f);
        sb_q.push_back('{data: f, crc: crc_of(f), err: 1'b0});
        fork
            sensor(f, 40);
            pulse_start();
        join
        wait_idle("read");
    endtask

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            check_eq("valid_busy", busy, 1);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("data", data, mon_e.data);
                check_eq("crc_ok", crc_ok, mon_e.crc);
                check_eq("err_timeout", err_timeout, mon_e.err);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_a) begin
            n_valid_a++;
            check_eq("auto_err", err_a, 1);
            check_eq("auto_data", data_a, 0);
            check_eq("auto_crc", crc_a, 0);
        end
    end

    initial begin
        #60_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        fork
            begin : main_flow
                int t, v0;
                repeat (4) @(negedge clk);
                check_eq("rst_oe", dht_oe, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_valid", valid, 0);
                check_eq("rst_data", data, 0);
                check_eq("rst_crc", crc_ok, 0);
                check_eq("rst_err", err_timeout, 0);
                reset = 1'b0;
                repeat (10) @(negedge clk);

                do_read(F1);
                do_read(F2);

                // Silent sensor: timeout 200 us after release, then 2 ms cooldown.
                sb_q.push_back('{data: 40'h0, crc: 1'b0, err: 1'b1});
                pulse_start();
                t = 0;
                while (dht_oe && t < LIMIT) begin @(negedge clk); t++; end
                t = 0;
                while (!valid && t < LIMIT) begin @(negedge clk); t++; end
                check_eq("silent_latency", (t >= 200*CPU - 4) && (t <= 200*CPU + 6), 1);
                t = 0;
                while (busy && t < LIMIT) begin @(negedge clk); t++; end
                check_eq("silent_cooldown", (t >= 2000*CPU - 5) && (t <= 2000*CPU + 10), 1);
                repeat (10) @(negedge clk);

                // Stuck after bit 12: its falling edge never arrives, so only 11 bits are shifted in.
                sb_q.push_back('{data: (F4 >> 29) << 29, crc: 1'b0, err: 1'b1});
                v0 = n_valid;
                fork
                    sensor(F4, 12);
                    pulse_start();
                join
                t = 0;
                while (n_valid == v0 && t < LIMIT) begin @(negedge clk); t++; end
                check_eq("stuck_valid_seen", t < LIMIT, 1);
                for (int k = 0; k < 3; k++) begin
                    repeat (1000) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk) start = 1'b0;
                end
                wait_idle("stuck");
                repeat (300) @(negedge clk);
                check_eq("stuck_no_requeue_busy", busy, 0);
                check_eq("stuck_no_requeue_oe", dht_oe, 0);
                check_eq("stuck_valid_count", n_valid - v0, 1);

                // Reset during bit 20, then a clean read.
                fork
                    sensor(F3, 40);
                    pulse_start();
                    begin
                        int tr;
                        tr = 0;
                        while (bit_idx != 20 && tr < LIMIT) begin @(negedge clk); tr++; end
                        check_eq("reset_reached_bit20", tr < LIMIT, 1);
                        check_eq("busy_before_reset", busy, 1);
                        reset = 1'b1;
                        @(negedge clk);
                        check_eq("mid_rst_oe", dht_oe, 0);
                        check_eq("mid_rst_busy", busy, 0);
                        check_eq("mid_rst_valid", valid, 0);
                        check_eq("mid_rst_data", data, 0);
                        check_eq("mid_rst_crc", crc_ok, 0);
                        check_eq("mid_rst_err", err_timeout, 0);
                        reset = 1'b0;
                    end
                join
                repeat (100) @(negedge clk);
                do_read(F3);
                check_eq("main_valid_total", n_valid, 5);
            end
            begin : auto_flow
                int t;
                repeat (4) @(negedge clk);
                reset_a = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    t = 0;
                    while (!oe_a && t < LIMIT) begin @(negedge clk); t++; end
                    check_eq("auto_gap", (t >= 3000*CPU - 6) && (t <= 3000*CPU + 10), 1);
                    t = 0;
                    while (busy_a && t < LIMIT) begin @(negedge clk); t++; end
                    check_eq("auto_busy_idle", t < LIMIT, 1);
                end
                check_eq("auto_valid_count", n_valid_a, 3);
            end
        join
        check_eq("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
